// File: rtl/wdg_sequencer.sv
// Watchdog configuration/refresh sequencer acting as a Wishbone master.
// Define WDG_SEQ_SR_POLL_EN to poll SR until the watchdog is ready before reload.
module wdg_sequencer #(
    parameter logic [31:0] BASE_ADR    = 32'h0100_0000,
    parameter int unsigned KICK_W      = 16,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        cfg_pr,
    input  logic [11:0]       cfg_rlr,
    input  logic [KICK_W-1:0] kick_period,
    input  logic              alive,
    output logic              cyc_m2s,
    output logic              stb_m2s,
    output logic              we_m2s,
    output logic [31:0]       adr_m2s,
    output logic [15:0]       dat_m2s,
    input  logic [15:0]       dat_s2m,
    input  logic              ack_s2m,
    output logic              running,
    output logic              starved,
    output logic              err
);

    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [31:0] ADR_KR  = BASE_ADR;
    localparam logic [31:0] ADR_PR  = BASE_ADR + 32'h4;
    localparam logic [31:0] ADR_RLR = BASE_ADR + 32'h8;
    localparam logic [31:0] ADR_SR  = BASE_ADR + 32'hC;

    typedef enum logic [3:0] {
        StIdle, StUnlock, StWrRlr, StWrPr, StPollSr, StReload, StArm, StRun, StKick, StFault
    } state_e;

    state_e            state_q, state_d;
    logic              cyc_q, cyc_d, we_q, we_d;
    logic [31:0]       adr_q, adr_d;
    logic [15:0]       dat_q, dat_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [KICK_W-1:0] cnt_q, cnt_d;
    logic [2:0]        pr_q, pr_d;
    logic [11:0]       rlr_q, rlr_d;
    logic              starved_q, starved_d, err_q, err_d;
    logic              alive_seen_q, alive_seen_d, running_q, running_d;

    logic              bus_req, clr_alive;
    logic [31:0]       req_adr;
    logic [15:0]       req_dat;
    logic              req_we;
    state_e            req_next;
    logic [KICK_W-1:0] load_val;

    // SR status is only consumed when polling is compiled in.
    logic unused_dat_s2m;
    assign unused_dat_s2m = ^dat_s2m;

    assign load_val = (kick_period == '0) ? KICK_W'(1) : kick_period;

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        pr_d      = pr_q;
        rlr_d     = rlr_q;
        starved_d = starved_q;
        err_d     = err_q;
        clr_alive = 1'b0;
        bus_req   = 1'b0;
        req_adr   = ADR_KR;
        req_dat   = 16'h0000;
        req_we    = 1'b1;
        req_next  = state_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pr_d    = cfg_pr;
                    rlr_d   = cfg_rlr;
                    state_d = StUnlock;
                end
            end
            StUnlock: begin
                bus_req  = 1'b1;
                req_dat  = 16'h5555;
                req_next = StWrRlr;
            end
            StWrRlr: begin
                bus_req  = 1'b1;
                req_adr  = ADR_RLR;
                req_dat  = {4'b0, rlr_q};
                req_next = StWrPr;
            end
            StWrPr: begin
                bus_req  = 1'b1;
                req_adr  = ADR_PR;
                req_dat  = {13'b0, pr_q};
`ifdef WDG_SEQ_SR_POLL_EN
                req_next = StPollSr;
`else
                req_next = StReload;
`endif
            end
            StPollSr: begin
`ifdef WDG_SEQ_SR_POLL_EN
                bus_req  = 1'b1;
                req_adr  = ADR_SR;
                req_we   = 1'b0;
                req_next = StReload;
`else
                state_d  = StReload;
`endif
            end
            StReload: begin
                bus_req  = 1'b1;
                req_dat  = 16'hAAAA;
                req_next = StArm;
            end
            StArm: begin
                bus_req  = 1'b1;
                req_dat  = 16'hCCCC;
                req_next = StRun;
            end
            StRun: begin
                // Reload at the decision point so the refresh cadence ignores bus latency.
                if (cnt_q == '0) begin
                    cnt_d = load_val;
                    if (alive_seen_q) begin
                        clr_alive = 1'b1;
                        state_d   = StKick;
                    end else begin
                        starved_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StKick: begin
                bus_req  = 1'b1;
                req_dat  = 16'hAAAA;
                req_next = StRun;
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            StFault: begin
            end
            default: state_d = StFault;
        endcase

        if (bus_req) begin
            if (!cyc_q) begin
                cyc_d = 1'b1;
                adr_d = req_adr;
                dat_d = req_dat;
                we_d  = req_we;
                tmo_d = '0;
            end else if (ack_s2m) begin
                cyc_d   = 1'b0;
                state_d = req_next;
`ifdef WDG_SEQ_SR_POLL_EN
                if (state_q == StPollSr && dat_s2m[1:0] != 2'b00) state_d = StPollSr;
`endif
                if (state_q == StArm) cnt_d = load_val;
            end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                cyc_d   = 1'b0;
                err_d   = 1'b1;
                state_d = StFault;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        alive_seen_d = alive | (alive_seen_q & ~clr_alive);
        running_d    = (state_d == StRun) || (state_d == StKick);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            tmo_q        <= '0;
            cnt_q        <= '0;
            pr_q         <= '0;
            rlr_q        <= '0;
            starved_q    <= 1'b0;
            err_q        <= 1'b0;
            alive_seen_q <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            tmo_q        <= tmo_d;
            cnt_q        <= cnt_d;
            pr_q         <= pr_d;
            rlr_q        <= rlr_d;
            starved_q    <= starved_d;
            err_q        <= err_d;
            alive_seen_q <= alive_seen_d;
            running_q    <= running_d;
        end
    end

    assign cyc_m2s = cyc_q;
    assign stb_m2s = cyc_q;
    assign we_m2s  = we_q;
    assign adr_m2s = adr_q;
    assign dat_m2s = dat_q;
    assign running = running_q;
    assign starved = starved_q;
    assign err     = err_q;

endmodule
